// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU control unit: instruction fields,
// opcodes, controller states and datapath select codes.
package cpu_pkg;

  // Instruction word fields
  localparam int OPC_HI  = 9;
  localparam int OPC_LO  = 6;
  localparam int ADDR_HI = 5;
  localparam int ADDR_LO = 0;

  // Opcodes (A..E are undefined)
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_IN    = 4'h6;
  localparam logic [3:0] OP_OUT   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Controller states
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM_RD = 3'd2,
    S_MEM_WR = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // ALU operation codes (B operand is memory read data)
  localparam logic [1:0] ALU_PASS_B = 2'b00;
  localparam logic [1:0] ALU_ADD    = 2'b01;
  localparam logic [1:0] ALU_SUB    = 2'b10;
  localparam logic [1:0] ALU_AND    = 2'b11;

  // Accumulator source select
  localparam logic ACC_SRC_ALU    = 1'b0;
  localparam logic ACC_SRC_DATAIN = 1'b1;

  // Opcodes A..E have no defined behaviour and execute as NOP
  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags when the limit is reached.
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);

  logic [CW-1:0] count;

  // Wait-cycle counter; holds at the limit until cleared
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CW'(WAIT_LIMIT));

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control unit for the 10-bit accumulator CPU: sequences fetch,
// decode, memory access and execute, and drives every datapath strobe.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       acc_zero,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       acc_load,
  output logic       acc_src,
  output logic [1:0] alu_op,
  output logic       out_load,
  output logic       halted,
  output logic       illegal_op,
  output logic       bus_timeout
);

  state_t state;
  state_t state_next;
  logic   illegal_q;
  logic   timeout_q;
  logic   wait_cycle;
  logic   expired;
  logic   timeout;

  // A memory state with no completion this cycle is a wait cycle
  assign wait_cycle = ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR))
                      && !mem_ready;
  assign timeout    = wait_cycle && expired;

  mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    ((state_next != state) || !wait_cycle),
    .count_en (wait_cycle),
    .expired  (expired)
  );

  // Next-state selection
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_FETCH: begin
        if (timeout)        state_next = S_HALT;
        else if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND: state_next = S_MEM_RD;
          OP_STORE:                        state_next = S_MEM_WR;
          OP_IN, OP_OUT, OP_JMP, OP_JZ:    state_next = S_EXEC;
          OP_HALT:                         state_next = S_HALT;
          default:                         state_next = S_FETCH;
        endcase
      end
      S_MEM_RD, S_MEM_WR: begin
        if (timeout)        state_next = S_HALT;
        else if (mem_ready) state_next = S_FETCH;
      end
      S_EXEC:  state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  // State register and sticky error flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == S_DECODE) && is_illegal(opcode)) illegal_q <= 1'b1;
      if (timeout)                                   timeout_q <= 1'b1;
    end
  end

  // Strobe decode; reset and a timeout cycle suppress every strobe
  always_comb begin
    mem_rd   = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    acc_load = 1'b0;
    acc_src  = ACC_SRC_ALU;
    alu_op   = ALU_PASS_B;
    out_load = 1'b0;
    if (!reset && !timeout) begin
      case (state)
        S_FETCH: begin
          mem_rd  = 1'b1;
          ir_load = mem_ready;
          pc_inc  = mem_ready;
        end
        S_MEM_RD: begin
          mem_rd   = 1'b1;
          addr_sel = 1'b1;
          acc_load = mem_ready;
          case (opcode)
            OP_ADD:  alu_op = ALU_ADD;
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            default: alu_op = ALU_PASS_B;
          endcase
        end
        S_MEM_WR: begin
          mem_we   = 1'b1;
          addr_sel = 1'b1;
        end
        S_EXEC: begin
          case (opcode)
            OP_IN: begin
              acc_load = 1'b1;
              acc_src  = ACC_SRC_DATAIN;
            end
            OP_OUT:  out_load = 1'b1;
            OP_JMP:  pc_load  = 1'b1;
            OP_JZ:   pc_load  = acc_zero;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign halted      = !reset && (state == S_HALT);
  assign illegal_op  = !reset && illegal_q;
  assign bus_timeout = !reset && timeout_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: directed instruction sequences, an
// instruction-step reference model checked every cycle, and literal spot checks.
module tb_cpu_ctrl;

  localparam int WL = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       acc_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_rd, mem_we, addr_sel, ir_load, pc_inc, pc_load;
  logic       acc_load, acc_src, out_load, halted, illegal_op, bus_timeout;
  logic [1:0] alu_op;

  int checks = 0;
  int errors = 0;

  cpu_ctrl #(.WAIT_LIMIT(WL)) dut (
    .clock       (clock),
    .reset       (reset),
    .opcode      (opcode),
    .acc_zero    (acc_zero),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_we      (mem_we),
    .addr_sel    (addr_sel),
    .ir_load     (ir_load),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .acc_load    (acc_load),
    .acc_src     (acc_src),
    .alu_op      (alu_op),
    .out_load    (out_load),
    .halted      (halted),
    .illegal_op  (illegal_op),
    .bus_timeout (bus_timeout)
  );

  always #5 clock = ~clock;

  // Output bundle: [13]mem_rd [12]mem_we [11]addr_sel [10]ir_load [9]pc_inc [8]pc_load
  // [7]acc_load [6]acc_src [5:4]alu_op [3]out_load [2]halted [1]illegal_op [0]bus_timeout
  logic [13:0] dut_vec;
  assign dut_vec = {mem_rd, mem_we, addr_sel, ir_load, pc_inc, pc_load,
                    acc_load, acc_src, alu_op, out_load, halted, illegal_op, bus_timeout};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_step: position inside the current instruction (0 fetch, 1 decode, 2 third cycle)
  int   m_step = 0;
  int   m_wait = 0;
  logic m_halt = 1'b0;
  logic m_ill  = 1'b0;
  logic m_to   = 1'b0;

  function automatic bit has_mem(input logic [3:0] op);
    return op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
  endfunction

  function automatic logic [13:0] model_expect();
    logic mrd, mwe, asel, irl, pinc, pld, accl, accs, ol, stall_out;
    logic [1:0] aop;
    {mrd, mwe, asel, irl, pinc, pld, accl, accs, ol} = '0;
    aop = 2'b00;
    stall_out = !mem_ready && (m_wait == WL);
    if (!reset && !m_halt) begin
      if (m_step == 0) begin
        if (!stall_out) begin
          mrd = 1'b1; irl = mem_ready; pinc = mem_ready;
        end
      end else if (m_step == 2) begin
        case (opcode)
          4'h1, 4'h3, 4'h4, 4'h5: if (!stall_out) begin
            mrd = 1'b1; asel = 1'b1; accl = mem_ready;
            aop = (opcode == 4'h1) ? 2'b00 : (opcode == 4'h3) ? 2'b01 :
                  (opcode == 4'h4) ? 2'b10 : 2'b11;
          end
          4'h2: if (!stall_out) begin mwe = 1'b1; asel = 1'b1; end
          4'h6: begin accl = 1'b1; accs = 1'b1; end
          4'h7: ol = 1'b1;
          4'h8: pld = 1'b1;
          4'h9: pld = acc_zero;
          default: ;
        endcase
      end
    end
    return {mrd, mwe, asel, irl, pinc, pld, accl, accs, aop, ol,
            !reset && m_halt, !reset && m_ill, !reset && m_to};
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_step <= 0; m_wait <= 0; m_halt <= 1'b0; m_ill <= 1'b0; m_to <= 1'b0;
    end else if (!m_halt) begin
      if (m_step == 1) begin
        if (opcode inside {[4'hA:4'hE]}) m_ill <= 1'b1;
        if (opcode == 4'hF)                  m_halt <= 1'b1;
        else if (opcode inside {[4'h1:4'h9]}) m_step <= 2;
        else                                 m_step <= 0;
      end else if (m_step == 0 || has_mem(opcode)) begin
        if (mem_ready) begin
          m_step <= (m_step == 0) ? 1 : 0;
          m_wait <= 0;
        end else if (m_wait == WL) begin
          m_to <= 1'b1; m_halt <= 1'b1; m_wait <= 0;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else begin
        m_step <= 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    check("cycle_vs_model", {2'b00, dut_vec}, {2'b00, model_expect()});
    check("strobe_exclusive", {14'b0, pc_inc & pc_load, mem_rd & mem_we}, 16'h0);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic r, input logic [3:0] op, input logic rdy, input logic az);
    @(posedge clock);
    #1;
    reset = r; opcode = op; mem_ready = rdy; acc_zero = az;
    #1;
  endtask

  // Zero-wait instruction: fetch, decode, and a third cycle where one exists
  task automatic run_instr(input logic [3:0] op, input logic az);
    cyc(1'b0, op, 1'b1, az);
    cyc(1'b0, op, 1'b1, az);
    if (op inside {[4'h1:4'h9]}) cyc(1'b0, op, 1'b1, az);
  endtask

  int pinc_cnt;

  initial begin
    // Reset state
    cyc(1'b1, 4'h0, 1'b1, 1'b0);
    cyc(1'b1, 4'h0, 1'b1, 1'b0);
    check("reset_outputs", {2'b00, dut_vec}, 16'h0);

    // Reset then NOP: FETCH, DECODE, FETCH
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    check("nop_fetch", {mem_rd, addr_sel, ir_load, pc_inc}, 4'b1011);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    check("nop_decode_quiet", {2'b00, dut_vec}, 16'h0);
    cyc(1'b0, 4'h3, 1'b1, 1'b0);
    check("nop_refetch", {mem_rd, ir_load}, 2'b11);

    // ADD with 2 wait states (fetch already done above)
    cyc(1'b0, 4'h3, 1'b1, 1'b0);
    cyc(1'b0, 4'h3, 1'b0, 1'b0);
    check("add_wait1", {mem_rd, addr_sel, acc_load, alu_op}, 5'b11001);
    cyc(1'b0, 4'h3, 1'b0, 1'b0);
    check("add_wait2", {mem_rd, addr_sel, acc_load, alu_op}, 5'b11001);
    cyc(1'b0, 4'h3, 1'b1, 1'b0);
    check("add_complete", {mem_rd, addr_sel, acc_load, acc_src, alu_op}, 6'b111001);

    // JZ taken and not taken; pc_inc pulses once per instruction
    pinc_cnt = 0;
    cyc(1'b0, 4'h9, 1'b1, 1'b1); pinc_cnt += int'(pc_inc);
    cyc(1'b0, 4'h9, 1'b1, 1'b1); pinc_cnt += int'(pc_inc);
    cyc(1'b0, 4'h9, 1'b1, 1'b1); pinc_cnt += int'(pc_inc);
    check("jz_taken", {pc_load, pc_inc}, 2'b10);
    check("jz_pc_inc_once", 16'(pinc_cnt), 16'd1);
    cyc(1'b0, 4'h9, 1'b1, 1'b0);
    cyc(1'b0, 4'h9, 1'b1, 1'b0);
    cyc(1'b0, 4'h9, 1'b1, 1'b0);
    check("jz_not_taken", {pc_load, pc_inc}, 2'b00);

    // IN then OUT
    cyc(1'b0, 4'h6, 1'b1, 1'b0);
    cyc(1'b0, 4'h6, 1'b1, 1'b0);
    cyc(1'b0, 4'h6, 1'b1, 1'b0);
    check("in_exec", {acc_load, acc_src, out_load}, 3'b110);
    cyc(1'b0, 4'h7, 1'b1, 1'b0);
    cyc(1'b0, 4'h7, 1'b1, 1'b0);
    cyc(1'b0, 4'h7, 1'b1, 1'b0);
    check("out_exec", {acc_load, out_load}, 2'b01);

    // Remaining instruction classes, zero wait
    run_instr(4'h1, 1'b0);
    run_instr(4'h4, 1'b0);
    run_instr(4'h5, 1'b0);
    run_instr(4'h8, 1'b0);
    // STORE with one wait cycle
    cyc(1'b0, 4'h2, 1'b1, 1'b0);
    cyc(1'b0, 4'h2, 1'b1, 1'b0);
    cyc(1'b0, 4'h2, 1'b0, 1'b0);
    check("store_wait", {mem_we, mem_rd, addr_sel}, 3'b101);
    cyc(1'b0, 4'h2, 1'b1, 1'b0);
    check("store_complete", {mem_we, addr_sel}, 2'b11);

    // Illegal opcode 0xC behaves as NOP, flag rises after DECODE and sticks
    cyc(1'b0, 4'hC, 1'b1, 1'b0);
    cyc(1'b0, 4'hC, 1'b1, 1'b0);
    check("illegal_not_yet", {15'b0, illegal_op}, 16'h0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    check("illegal_set_refetch", {illegal_op, mem_rd, ir_load}, 3'b111);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    check("illegal_sticky", {15'b0, illegal_op}, 16'h1);

    // HALT, then 20 idle cycles with arbitrary mem_ready
    cyc(1'b0, 4'hF, 1'b1, 1'b0);
    cyc(1'b0, 4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 4'hF, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("halt_idle", {4'b0, halted, dut_vec[13:3]}, {4'b0, 1'b1, 11'b0});
    end
    cyc(1'b1, 4'h0, 1'b1, 1'b0);
    check("reset_clears_flags", {halted, illegal_op, bus_timeout}, 3'b000);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    check("reset_leaves_halt", {halted, mem_rd}, 2'b01);

    // mem_ready stuck low in FETCH: 4 wait cycles, then timeout
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'h0, 1'b0, 1'b0);
    check("fetch_wait4", {mem_rd, bus_timeout}, 2'b10);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    check("timeout_cycle_quiet", {2'b00, dut_vec}, 16'h0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    check("timeout_halt", {halted, bus_timeout, mem_rd}, 3'b110);

    // Reset mid-MEM_WR gates the write in the reset cycle
    cyc(1'b1, 4'h0, 1'b1, 1'b0);
    cyc(1'b0, 4'h2, 1'b1, 1'b0);
    cyc(1'b0, 4'h2, 1'b1, 1'b0);
    cyc(1'b0, 4'h2, 1'b0, 1'b0);
    check("memwr_before_reset", {15'b0, mem_we}, 16'h1);
    cyc(1'b1, 4'h2, 1'b1, 1'b0);
    check("memwr_reset_gated", {2'b00, dut_vec}, 16'h0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    check("after_reset_fetch", {mem_rd, mem_we, ir_load}, 3'b101);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle control unit that sequences the 10-bit accumulator datapath of `CPU`. It fetches 10-bit instruction words, decodes the 4-bit opcode in `IR[9:6]`, and drives every datapath strobe. That covers the PC, IR, accumulator, ALU, the `datain`/`dataout` port registers, and the memory handshake. It replaces ad-hoc strobe generation inside `CPU`, and `CPU` instantiates it next to the datapath.

## Interface
- `WAIT_LIMIT`, 15: maximum cycles `mem_ready` may stay low in a memory state before a bus timeout (1..255).
- `clock` in 1: sole clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 4: `IR[9:6]`; valid from DECODE onward.
- `acc_zero` in 1: accumulator == 0.
- `mem_ready` in 1: memory completes the current read or write in this cycle.
- `mem_rd` out 1: memory read request.
- `mem_we` out 1: memory write request; write data is the accumulator.
- `addr_sel` out 1: memory address select; 0 = PC, 1 = `IR[5:0]`.
- `ir_load` out 1: IR <= memory read data.
- `pc_inc` out 1: PC <= PC+1, wrapping mod 64.
- `pc_load` out 1: PC <= `IR[5:0]`.
- `acc_load` out 1: accumulator <= selected source.
- `acc_src` out 1: accumulator source; 0 = ALU result, 1 = `datain`.
- `alu_op` out 2: 00 PASS_B (B = memory data), 01 ADD, 10 SUB, 11 AND. Results truncate to 10 bits.
- `out_load` out 1: `dataout` register <= accumulator.
- `halted` out 1: in HALT state.
- `illegal_op` out 1: sticky; an undefined opcode was decoded.
- `bus_timeout` out 1: sticky; the wait limit was exceeded.

## Operation
- Opcodes:
  - 0 NOP; 1 LOAD; 2 STORE; 3 ADD; 4 SUB; 5 AND
  - 6 IN (acc <= `datain`); 7 OUT (`dataout` <= acc)
  - 8 JMP; 9 JZ (jump if `acc_zero`); F HALT
  - A–E are illegal: `illegal_op` is set, then the instruction executes as NOP.
- States: FETCH, DECODE, MEM_RD, MEM_WR, EXEC, HALT. State is a register. Outputs are combinational from state, `opcode`, `mem_ready` and `acc_zero`.
- FETCH:
  - Drives `mem_rd`=1 and `addr_sel`=0.
  - On `mem_ready`: `ir_load`=1 and `pc_inc`=1 in the same cycle, then go to DECODE.
- DECODE (one cycle, no strobes):
  - LOAD, ADD, SUB, AND -> MEM_RD
  - STORE -> MEM_WR
  - IN, OUT, JMP, JZ -> EXEC
  - HALT -> HALT
  - NOP and illegal opcodes -> FETCH
- MEM_RD:
  - Drives `mem_rd`=1 and `addr_sel`=1, with `alu_op` set per opcode (LOAD uses PASS_B).
  - On `mem_ready`: `acc_load`=1 with `acc_src`=0, then go to FETCH.
- MEM_WR:
  - Drives `mem_we`=1 and `addr_sel`=1.
  - On `mem_ready`, go to FETCH. The write takes effect in that cycle.
- EXEC (one cycle), then FETCH:
  - IN: `acc_load`=1, `acc_src`=1.
  - OUT: `out_load`=1.
  - JMP: `pc_load`=1.
  - JZ: `pc_load`=`acc_zero`.
- HALT:
  - All strobes 0; `halted`=1.
  - Only `reset` leaves HALT.
- Wait timer:
  - Counts consecutive cycles spent in FETCH, MEM_RD or MEM_WR with `mem_ready`=0.
  - Clears on any state change.
  - When it reaches `WAIT_LIMIT` with `mem_ready` still 0: set `bus_timeout`, go to HALT, and drop all strobes in that same cycle.
- Strobe exclusivity: `pc_inc` and `pc_load` are never high together. `mem_rd` and `mem_we` are never high together.

## Timing
- Reset:
  - While `reset`=1: state = FETCH, timer = 0, `illegal_op` = 0, `bus_timeout` = 0, all strobes forced to 0.
  - The first fetch request appears in the cycle after `reset` deasserts.
  - Reset mid-instruction abandons the instruction with no partial writes: strobes are gated in the reset cycle.
- Instruction latency with zero-wait memory (`mem_ready`=1 in every memory cycle), counted from FETCH entry to the next FETCH entry:
  - NOP / illegal: 2 cycles
  - All other executed instructions: 3 cycles
  - Each wait cycle adds 1.
- `mem_ready` is sampled only in memory states; it is ignored elsewhere.
- A JZ that reads `acc_zero` sees the accumulator value produced by the preceding instruction.
- `illegal_op` rises in the cycle after the DECODE of the offending opcode.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams
  - state encoding (3 bits)
  - `alu_op` codes
  - `acc_src` codes
  - instruction field positions: opcode `[9:6]`, address `[5:0]`
- One sub-module, `mem_wait_timer`:
  - Inputs: `clock`, `reset`, clear, count-enable.
  - Output: expired flag.
  - Counter width sized by `WAIT_LIMIT`.
- The FSM and the output decode stay in `cpu_ctrl`.

## Test plan
- **Reset then NOP:** release `reset`, `mem_ready`=1, IR=`0x000` -> `mem_rd` and `ir_load` in cycle 1, DECODE in cycle 2, FETCH again in cycle 3, all strobes 0 during DECODE.
- **ADD with 2 wait states:** opcode 3, `mem_ready` low for 2 MEM_RD cycles -> `mem_rd`=1 and `addr_sel`=1 held for 3 cycles, `acc_load`=1 with `alu_op`=01 only in the third.
- **JZ with `acc_zero`=1 vs `acc_zero`=0:** opcode 9 -> `pc_load`=1 in EXEC only when `acc_zero`=1. `pc_inc` pulses exactly once, in FETCH.
- **IN/OUT with `datain`=10:** IN -> `acc_load`=1, `acc_src`=1 in EXEC. Following OUT -> `out_load`=1 in its EXEC.
- **Opcode `0xC`, then HALT `0xF`:** `illegal_op`=1 the cycle after DECODE and stays set, and the instruction behaves as NOP. After HALT, `halted`=1 and strobes stay 0 for 20 cycles. `reset` -> FETCH.
- **`WAIT_LIMIT`=4, `mem_ready` stuck 0 in FETCH:** `bus_timeout`=1 and HALT after 4 wait cycles. A reset asserted mid-MEM_WR instead yields no `mem_we` in the reset cycle.
